llc_rst_flush_sweep: RTL and testbench

// - Sequencer for the LLC set-walk that runs on reset and on flush. It sits next to the LLC

---
 rtl/llc_rst_flush_sweep_if.sv | 28 ++
 rtl/llc_rst_flush_sweep.sv | 133 +++++++++++++
 tb/tb_llc_rst_flush_sweep.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/llc_rst_flush_sweep_if.sv
// rtl/llc_rst_flush_sweep_if.sv - request/strobe and status bundle between the LLC sweep sequencer and its user
interface llc_rst_flush_sweep_if #(
   parameter int SET_BITS = 9
);
   logic                rst_start_i;
   logic                flush_start_i;
   logic                incr_i;
   logic [SET_BITS-1:0] set_o;
   logic                is_rst_sweep_o;
   logic                is_flush_sweep_o;
   logic                rst_stall_o;
   logic                flush_stall_o;
   logic                busy_o;
   logic                sweep_done_o;
   logic [31:0]         sweep_cycles_o;

   modport master (
      output rst_start_i, flush_start_i, incr_i,
      input  set_o, is_rst_sweep_o, is_flush_sweep_o, rst_stall_o, flush_stall_o,
             busy_o, sweep_done_o, sweep_cycles_o
   );

   modport slave (
      input  rst_start_i, flush_start_i, incr_i,
      output set_o, is_rst_sweep_o, is_flush_sweep_o, rst_stall_o, flush_stall_o,
             busy_o, sweep_done_o, sweep_cycles_o
   );
endinterface

// File: rtl/llc_rst_flush_sweep.sv
// rtl/llc_rst_flush_sweep.sv - LLC reset/flush set-walk sequencer
// Optional sweep duration counter built when LLC_SWEEP_PERF_CNT_EN is defined.
module llc_rst_flush_sweep #(
   parameter int SETS           = 512,
   parameter int SET_BITS       = 9,
   parameter bit AUTO_RST_SWEEP = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   llc_rst_flush_sweep_if.slave  sw
);
   localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(SETS - 1);

   typedef enum logic [1:0] {IDLE, RST, FLUSH, DONE} state_t;

   state_t              state, state_nxt;
   logic [SET_BITS-1:0] set_q, set_nxt;
   logic                pending_q, pending_nxt;
   logic                restart;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= AUTO_RST_SWEEP ? RST : IDLE;
         set_q     <= '0;
         pending_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         set_q     <= set_nxt;
         pending_q <= pending_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      set_nxt     = set_q;
      pending_nxt = pending_q;
      restart     = 1'b0;
      case (state)
         IDLE: begin
            set_nxt = '0;
            if (sw.rst_start_i) begin
               state_nxt   = RST;
               pending_nxt = sw.flush_start_i;
            end else if (sw.flush_start_i) begin
               state_nxt = FLUSH;
            end
         end
         RST: begin
            if (sw.rst_start_i) begin
               set_nxt     = '0;
               restart     = 1'b1;
               pending_nxt = pending_q | sw.flush_start_i;
            end else begin
               if (sw.flush_start_i)
                  pending_nxt = 1'b1;
               if (sw.incr_i) begin
                  if (set_q == LAST_SET) begin
                     set_nxt   = '0;
                     state_nxt = DONE;
                  end else begin
                     set_nxt = set_q + SET_BITS'(1);
                  end
               end
            end
         end
         FLUSH: begin
            // A reset abandons the flush; it is re-queued so it reruns from set 0.
            if (sw.rst_start_i) begin
               state_nxt   = RST;
               set_nxt     = '0;
               pending_nxt = 1'b1;
            end else if (sw.incr_i) begin
               if (set_q == LAST_SET) begin
                  set_nxt   = '0;
                  state_nxt = DONE;
               end else begin
                  set_nxt = set_q + SET_BITS'(1);
               end
            end
         end
         DONE: begin
            set_nxt = '0;
            if (sw.rst_start_i) begin
               state_nxt   = RST;
               pending_nxt = pending_q | sw.flush_start_i;
            end else if (pending_q | sw.flush_start_i) begin
               state_nxt   = FLUSH;
               pending_nxt = 1'b0;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign sw.set_o            = set_q;
   assign sw.is_rst_sweep_o   = (state == RST);
   assign sw.is_flush_sweep_o = (state == FLUSH);
   assign sw.rst_stall_o      = (state == RST)   && (set_q != LAST_SET);
   assign sw.flush_stall_o    = (state == FLUSH) && (set_q != LAST_SET);
   assign sw.busy_o           = (state != IDLE);
   assign sw.sweep_done_o     = (state == DONE);

`ifdef LLC_SWEEP_PERF_CNT_EN
   logic [31:0] cnt_q, cnt_inc, cycles_q;
   logic        in_sweep, entering;

   assign cnt_inc  = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
   assign in_sweep = (state == RST) || (state == FLUSH);
   assign entering = ((state_nxt == RST) || (state_nxt == FLUSH)) &&
                     ((state_nxt != state) || restart);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         cycles_q <= '0;
      end else begin
         if (entering)
            cnt_q <= '0;
         else if (in_sweep)
            cnt_q <= cnt_inc;
         // Only a sweep that finishes publishes its length; aborts never reach DONE.
         if (in_sweep && (state_nxt == DONE))
            cycles_q <= cnt_inc;
      end
   end

   assign sw.sweep_cycles_o = cycles_q;
`else
   assign sw.sweep_cycles_o = 32'd0;
`endif
endmodule

// File: tb/tb_llc_rst_flush_sweep.sv
// tb/tb_llc_rst_flush_sweep.sv - scoreboard bench for llc_rst_flush_sweep (SETS=4)
module tb_llc_rst_flush_sweep;
   localparam int SETS     = 4;
   localparam int SET_BITS = 2;

   typedef enum int {E_IDLE, E_RST, E_FLUSH, E_DONE} exp_state_t;

   typedef struct {
      exp_state_t  st;
      logic [1:0]  set;
      string       tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];
   string cur_tag;

   always #5 clk = ~clk;

   llc_rst_flush_sweep_if #(.SET_BITS(SET_BITS)) sw ();

   llc_rst_flush_sweep #(
      .SETS(SETS), .SET_BITS(SET_BITS), .AUTO_RST_SWEEP(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sw (sw.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
   endtask

   // Drive one cycle of requests and queue the state expected right after that edge.
   task automatic step(input logic rs, input logic fs, input logic inc,
                       input exp_state_t st, input int s);
      exp_t e;
      @(negedge clk);
      sw.rst_start_i   = rs;
      sw.flush_start_i = fs;
      sw.incr_i        = inc;
      e.st  = st;
      e.set = 2'(s);
      e.tag = cur_tag;
      sb.push_back(e);
      @(posedge clk);
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         logic [5:0] want, got;
         logic r, f;
         e = sb.pop_front();
         r = (e.st == E_RST);
         f = (e.st == E_FLUSH);
         want = {e.st != E_IDLE, e.st == E_DONE, r, f,
                 r && (e.set != 2'd3), f && (e.set != 2'd3)};
         got  = {sw.busy_o, sw.sweep_done_o, sw.is_rst_sweep_o, sw.is_flush_sweep_o,
                 sw.rst_stall_o, sw.flush_stall_o};
         check({e.tag, ".flags"}, 32'(got), 32'(want));
         check({e.tag, ".set"}, 32'(sw.set_o), 32'(e.set));
      end
   end

   always @(posedge clk) begin
      if (!rst)
         assert (!(sw.incr_i && (!sw.busy_o || sw.sweep_done_o)))
            else $error("incr_i asserted while not sweeping");
   end

   task automatic run_sweep(input exp_state_t st);
      for (int i = 1; i <= SETS; i++)
         step(0, 0, 1, (i == SETS) ? E_DONE : st, (i == SETS) ? 0 : i);
   endtask

   initial begin
      sw.rst_start_i   = 1'b0;
      sw.flush_start_i = 1'b0;
      sw.incr_i        = 1'b0;
      rst              = 1'b1;

      cur_tag = "reset";
      step(0, 0, 0, E_RST, 0);
      step(0, 0, 0, E_RST, 0);
      check("reset.cycles", sw.sweep_cycles_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      cur_tag = "boot";
      run_sweep(E_RST);
      step(0, 0, 0, E_IDLE, 0);
      step(0, 0, 0, E_IDLE, 0);

      cur_tag = "sparse";
      step(0, 1, 0, E_FLUSH, 0);
      for (int k = 1; k <= SETS; k++) begin
         step(0, (k == 2), 0, E_FLUSH, k - 1);
         step(0, 0, 0, E_FLUSH, k - 1);
         step(0, 0, 1, (k == SETS) ? E_DONE : E_FLUSH, (k == SETS) ? 0 : k);
      end
      step(0, 0, 0, E_IDLE, 0);
      step(0, 0, 0, E_IDLE, 0);

      cur_tag = "abort";
      step(0, 1, 0, E_FLUSH, 0);
      step(0, 0, 1, E_FLUSH, 1);
      step(0, 0, 1, E_FLUSH, 2);
      step(1, 0, 0, E_RST, 0);
      run_sweep(E_RST);
      step(0, 0, 0, E_FLUSH, 0);
      run_sweep(E_FLUSH);
      step(0, 0, 0, E_IDLE, 0);

      cur_tag = "both";
      step(1, 1, 0, E_RST, 0);
      run_sweep(E_RST);
      step(0, 0, 0, E_FLUSH, 0);
      run_sweep(E_FLUSH);
      step(0, 0, 0, E_IDLE, 0);

      cur_tag = "collide";
      step(1, 0, 0, E_RST, 0);
      step(0, 0, 1, E_RST, 1);
      step(1, 0, 1, E_RST, 0);
      run_sweep(E_RST);
      step(0, 0, 0, E_IDLE, 0);

      cur_tag = "flush_in_rst";
      step(1, 0, 0, E_RST, 0);
      step(0, 1, 1, E_RST, 1);
      step(0, 0, 1, E_RST, 2);
      step(0, 0, 1, E_RST, 3);
      step(0, 0, 1, E_DONE, 0);
      step(0, 0, 0, E_FLUSH, 0);
      run_sweep(E_FLUSH);
      step(0, 0, 0, E_IDLE, 0);

`ifdef LLC_SWEEP_PERF_CNT_EN
      cur_tag = "perf";
      step(0, 1, 0, E_FLUSH, 0);
      for (int k = 1; k <= SETS; k++) begin
         step(0, 0, 0, E_FLUSH, k - 1);
         step(0, 0, 1, (k == SETS) ? E_DONE : E_FLUSH, (k == SETS) ? 0 : k);
      end
      #2;
      check("perf.cycles", sw.sweep_cycles_o, 32'd8);
      step(0, 0, 0, E_IDLE, 0);
      step(0, 1, 0, E_FLUSH, 0);
      step(0, 0, 1, E_FLUSH, 1);
      step(1, 0, 0, E_RST, 0);
      #2;
      check("perf.abort_keep", sw.sweep_cycles_o, 32'd8);
      run_sweep(E_RST);
      step(0, 0, 0, E_FLUSH, 0);
      run_sweep(E_FLUSH);
      step(0, 0, 0, E_IDLE, 0);
`else
      #2;
      check("cycles_tied", sw.sweep_cycles_o, 32'd0);
`endif

      @(negedge clk);
      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
